pet_stats: RTL and testbench
============================

PET_STATS -- requirements
Module: pet_stats

Interface
REQ-001 Parameter: TICK_CYCLES, default 27_000_000, clk cycles per decay tick (1 s at 27 MHz); legal range 2..2^25-1.
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 cmd_byte  in  8  received UART byte; 8'h00 = no byte; a nonzero value may be held for many cycles.
REQ-005 hunger, happiness, hygiene, energy  out  5 each  need levels 0..15 (0 satisfied, 15 critical); bit 4 always 0.
REQ-006 is_sleeping  out  1  high in ASLEEP.
REQ-007 status  out  8  {dead, asleep, last_cmd[1:0], age[3:0]}.
REQ-008 cmd_ack  out  1  one-cycle pulse per accepted command.

Function
REQ-009 Command accept: cmd_byte nonzero this cycle and 8'h00 the previous cycle (registered previous value); any other cycle accepts nothing.
REQ-010 States: AWAKE, ASLEEP, DEAD; reset state AWAKE.
REQ-011 Decay tick: free-running prescaler pulses once every TICK_CYCLES cycles; it runs in all states.
REQ-012 Tick in AWAKE: hunger, happiness, hygiene +1 each; energy +1; all saturate at 15.
REQ-013 Tick in ASLEEP: hunger, happiness, hygiene +1 (saturating); energy -2, saturating at 0.
REQ-014 Tick in DEAD: stats frozen; age frozen.
REQ-015 Every tick outside DEAD increments age, saturating at 15.
REQ-016 'F' (8'h46) in AWAKE: hunger -4 (floor 0), hygiene +1 (cap 15); last_cmd=0.
REQ-017 'P' (8'h50) in AWAKE: happiness -4 (floor 0), energy +2 (cap 15); last_cmd=1.
REQ-018 'C' (8'h43) in AWAKE: hygiene=0; last_cmd=2.
REQ-019 'S' (8'h53) in AWAKE: go ASLEEP; last_cmd=3. 'W' (8'h57) in ASLEEP: go AWAKE; last_cmd=3.
REQ-020 ASLEEP ignores all commands except 'W'; ignored bytes produce no cmd_ack.
REQ-021 Auto-wake: energy is 0 after a sleep tick -> AWAKE on the next cycle.
REQ-022 Death: any stat == 15 at a clock edge -> DEAD next cycle, from AWAKE or ASLEEP.
REQ-023 'R' (8'h52) in DEAD: all stats 0, age 0, last_cmd 0, AWAKE; all other bytes in DEAD are ignored.
REQ-024 Unrecognised bytes are ignored in every state, with no cmd_ack.
REQ-025 Tick and accepted command on the same cycle: the command applies first; the tick is held pending and applies the next cycle; only one tick may be pending.
REQ-026 cmd_ack asserts one cycle after the accept cycle, concurrent with the updated stats.
REQ-027 Arithmetic: stats are held as 4-bit unsigned and zero-extended to outputs; saturation is computed on 5-bit intermediates.

Reset
REQ-028 rst_n low at a clock edge: stats 0, age 0, last_cmd 0, AWAKE, prescaler 0, pending tick cleared, previous-byte register 8'h00, cmd_ack 0.
REQ-029 Reset mid-operation discards any pending tick and any held command byte; a byte still held nonzero after release is not accepted until cmd_byte has returned to 00.

Configuration
REQ-030 PET_STATS_CHEAT_EN defined: 'T' (8'h54) in AWAKE or ASLEEP forces an immediate tick (REQ-012/013) with cmd_ack; last_cmd unchanged.
REQ-031 PET_STATS_CHEAT_EN undefined: 'T' is an unrecognised byte (REQ-024).

Structure
REQ-032 Shared package pet_pkg holds: state enum, command byte constants, STAT_MAX=15, and status bit positions.
REQ-033 Prescaler is sub-module pet_tick_gen (TICK_CYCLES parameter, rst_n, tick pulse out); all other logic stays in pet_stats.

Verification (bench TICK_CYCLES=10)
REQ-034 Reset, then 30 idle cycles -> 3 ticks: hunger=happiness=hygiene=energy=3, age=3.
REQ-035 Drive 'F' held for 50 cycles after hunger=6 -> exactly one cmd_ack; hunger=2; hygiene +1.
REQ-036 'S' at energy=5, then 3 ticks -> energy 3, 1, 0; is_sleeping drops the cycle after energy reaches 0; 'F' while asleep -> no ack.
REQ-037 Idle until hunger=15 -> status[7]=1 the next cycle; 'F' ignored; 'R' -> all stats 0, AWAKE, cmd_ack.
REQ-038 'C' on the same cycle as a tick, with hygiene=7 -> hygiene 0 then 1 on the next cycle; no tick lost.
REQ-039 With PET_STATS_CHEAT_EN, 'T' -> immediate +1 on the awake stats with cmd_ack; without the macro, 'T' -> no ack and no change.

Source files
------------

// File: rtl/pet_pkg.sv
// Shared types, command bytes and saturating helpers for the virtual pet.
// Optional build macro honoured by pet_stats: PET_STATS_CHEAT_EN.
package pet_pkg;

    typedef enum logic [1:0] {
        ST_AWAKE  = 2'd0,
        ST_ASLEEP = 2'd1,
        ST_DEAD   = 2'd2
    } pet_state_t;

    localparam logic [7:0] CMD_FEED   = 8'h46;
    localparam logic [7:0] CMD_PLAY   = 8'h50;
    localparam logic [7:0] CMD_CLEAN  = 8'h43;
    localparam logic [7:0] CMD_SLEEP  = 8'h53;
    localparam logic [7:0] CMD_WAKE   = 8'h57;
    localparam logic [7:0] CMD_REVIVE = 8'h52;
    localparam logic [7:0] CMD_TICK   = 8'h54;

    localparam logic [3:0] STAT_MAX = 4'd15;

    localparam int STATUS_DEAD_BIT   = 7;
    localparam int STATUS_ASLEEP_BIT = 6;
    localparam int STATUS_CMD_MSB    = 5;
    localparam int STATUS_CMD_LSB    = 4;
    localparam int STATUS_AGE_MSB    = 3;
    localparam int STATUS_AGE_LSB    = 0;

    // Saturation is decided on a 5-bit intermediate so carry/borrow is visible.
    function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, STAT_MAX}) ? STAT_MAX : s[3:0];
    endfunction

    function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[4] ? 4'd0 : d[3:0];
    endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Free-running decay prescaler: one-cycle tick every TICK_CYCLES clocks.
module pet_tick_gen
#(
    parameter int TICK_CYCLES = 27_000_000
)
(
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [24:0] cnt;

    assign tick = (cnt == 25'(TICK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 25'd1;
    end

endmodule

// File: rtl/pet_stats.sv
// Virtual pet need tracker: UART command decode, decay ticks, sleep/death FSM.
// Define PET_STATS_CHEAT_EN to make 'T' force an immediate decay tick.
module pet_stats
    import pet_pkg::*;
#(
    parameter int TICK_CYCLES = 27_000_000
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd_byte,
    output logic [4:0] hunger,
    output logic [4:0] happiness,
    output logic [4:0] hygiene,
    output logic [4:0] energy,
    output logic       is_sleeping,
    output logic [7:0] status,
    output logic       cmd_ack
);

    pet_state_t state;
    logic [3:0] hun, hap, hyg, eng, age;
    logic [1:0] last_cmd;
    logic [7:0] prev_byte;
    logic       tick_pend;
    logic       wake_due;

    logic       tick, tick_now, accept, cmd_ok, cheat_tick;
    logic       any_max, dying, do_cmd, apply_tick;
    logic [3:0] t_hun, t_hap, t_hyg, t_eng;

    pet_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        cmd_ok     = 1'b0;
        cheat_tick = 1'b0;
        case (state)
            ST_AWAKE:  cmd_ok = (cmd_byte == CMD_FEED)  || (cmd_byte == CMD_PLAY) ||
                                (cmd_byte == CMD_CLEAN) || (cmd_byte == CMD_SLEEP);
            ST_ASLEEP: cmd_ok = (cmd_byte == CMD_WAKE);
            ST_DEAD:   cmd_ok = (cmd_byte == CMD_REVIVE);
            default:   cmd_ok = 1'b0;
        endcase
`ifdef PET_STATS_CHEAT_EN
        if (cmd_byte == CMD_TICK && state != ST_DEAD) begin
            cmd_ok     = 1'b1;
            cheat_tick = 1'b1;
        end
`endif
        accept   = (cmd_byte != 8'h00) && (prev_byte == 8'h00);
        tick_now = tick || tick_pend;
        any_max  = (hun == STAT_MAX) || (hap == STAT_MAX) ||
                   (hyg == STAT_MAX) || (eng == STAT_MAX);
        // Death outranks everything else on the same edge.
        dying      = (state != ST_DEAD) && any_max;
        do_cmd     = !dying && accept && cmd_ok;
        apply_tick = !dying && (state != ST_DEAD) &&
                     ((do_cmd && cheat_tick) || (!do_cmd && tick_now));

        t_hun = sat_add(hun, 4'd1);
        t_hap = sat_add(hap, 4'd1);
        t_hyg = sat_add(hyg, 4'd1);
        t_eng = (state == ST_ASLEEP) ? sat_sub(eng, 4'd2) : sat_add(eng, 4'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_AWAKE;
            hun       <= '0;
            hap       <= '0;
            hyg       <= '0;
            eng       <= '0;
            age       <= '0;
            last_cmd  <= '0;
            prev_byte <= 8'h00;
            tick_pend <= 1'b0;
            wake_due  <= 1'b0;
            cmd_ack   <= 1'b0;
        end else begin
            prev_byte <= cmd_byte;
            cmd_ack   <= 1'b0;
            if (dying) begin
                state     <= ST_DEAD;
                tick_pend <= 1'b0;
                wake_due  <= 1'b0;
            end else begin
                // A tick colliding with a command is deferred by one cycle.
                tick_pend <= do_cmd ? tick_now : 1'b0;
                if (do_cmd) begin
                    cmd_ack <= 1'b1;
                    case (cmd_byte)
                        CMD_FEED: begin
                            hun      <= sat_sub(hun, 4'd4);
                            hyg      <= sat_add(hyg, 4'd1);
                            last_cmd <= 2'd0;
                        end
                        CMD_PLAY: begin
                            hap      <= sat_sub(hap, 4'd4);
                            eng      <= sat_add(eng, 4'd2);
                            last_cmd <= 2'd1;
                        end
                        CMD_CLEAN: begin
                            hyg      <= '0;
                            last_cmd <= 2'd2;
                        end
                        CMD_SLEEP: begin
                            state    <= ST_ASLEEP;
                            wake_due <= 1'b0;
                            last_cmd <= 2'd3;
                        end
                        CMD_WAKE: begin
                            state    <= ST_AWAKE;
                            wake_due <= 1'b0;
                            last_cmd <= 2'd3;
                        end
                        CMD_REVIVE: begin
                            state    <= ST_AWAKE;
                            hun      <= '0;
                            hap      <= '0;
                            hyg      <= '0;
                            eng      <= '0;
                            age      <= '0;
                            last_cmd <= 2'd0;
                        end
                        default: ;
                    endcase
                end
                if (apply_tick) begin
                    hun      <= t_hun;
                    hap      <= t_hap;
                    hyg      <= t_hyg;
                    eng      <= t_eng;
                    age      <= sat_add(age, 4'd1);
                    wake_due <= (state == ST_ASLEEP) && (t_eng == 4'd0);
                end else if (!do_cmd && state == ST_ASLEEP && wake_due) begin
                    state    <= ST_AWAKE;
                    wake_due <= 1'b0;
                end
            end
        end
    end

    assign hunger      = {1'b0, hun};
    assign happiness   = {1'b0, hap};
    assign hygiene     = {1'b0, hyg};
    assign energy      = {1'b0, eng};
    assign is_sleeping = (state == ST_ASLEEP);

    always_comb begin
        status = '0;
        status[STATUS_DEAD_BIT]                = (state == ST_DEAD);
        status[STATUS_ASLEEP_BIT]              = (state == ST_ASLEEP);
        status[STATUS_CMD_MSB:STATUS_CMD_LSB]  = last_cmd;
        status[STATUS_AGE_MSB:STATUS_AGE_LSB]  = age;
    end

endmodule

// File: tb/tb_pet_stats.sv
// Directed scoreboard bench for pet_stats with TICK_CYCLES=10 (ticks on every 10th edge).
module tb_pet_stats;

    typedef struct packed {
        logic [4:0] h;
        logic [4:0] hp;
        logic [4:0] hy;
        logic [4:0] e;
        logic [7:0] st;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic [4:0] hunger, happiness, hygiene, energy;
    logic       is_sleeping;
    logic [7:0] status;
    logic       cmd_ack;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    acks = 0;
    snap_t exp_q[$];

    pet_stats #(.TICK_CYCLES(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_byte    (cmd_byte),
        .hunger      (hunger),
        .happiness   (happiness),
        .hygiene     (hygiene),
        .energy      (energy),
        .is_sleeping (is_sleeping),
        .status      (status),
        .cmd_ack     (cmd_ack)
    );

    always #5 clk = ~clk;

    // Edges counted since reset release; ticks land on multiples of 10.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    function automatic snap_t cur();
        snap_t s;
        s = {hunger, happiness, hygiene, energy, status};
        return s;
    endfunction

    function automatic snap_t mk(input int h, input int hp, input int hy, input int e,
                                 input logic [7:0] st);
        snap_t s;
        s = {5'(h), 5'(hp), 5'(hy), 5'(e), st};
        return s;
    endfunction

    // Monitor: every cmd_ack must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && cmd_ack) begin
            snap_t e;
            acks++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected cyc=%0d got=%h", cyc, cur());
            end else begin
                e = exp_q.pop_front();
                if (cur() !== e) begin
                    errors++;
                    $display("FAIL ack_snapshot cyc=%0d got=%h want=%h", cyc, cur(), e);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, want);
        end
    endtask

    task automatic chk_snap(input string nm, input snap_t want);
        checks++;
        if (cur() !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, cur(), want);
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_snap("reset_stats", mk(0, 0, 0, 0, 8'h00));
        chk("reset_ack", int'(cmd_ack), 0);
        chk("reset_sleep", int'(is_sleeping), 0);
        rst_n = 1'b1;

        run_to(30);
        chk_snap("idle_3_ticks", mk(3, 3, 3, 3, 8'h03));

        // Clean lands on the tick edge 80; the tick follows one cycle later.
        run_to(79);
        chk_snap("pre_clean", mk(7, 7, 7, 7, 8'h07));
        cmd_byte = 8'h43;
        exp_q.push_back(mk(7, 7, 0, 7, 8'h27));
        run_to(80);
        cmd_byte = 8'h00;
        run_to(81);
        chk_snap("pending_tick", mk(8, 8, 1, 8, 8'h28));
        run_to(90);
        chk_snap("next_tick", mk(9, 9, 2, 9, 8'h29));

        run_to(150);
        chk_snap("hunger_max", mk(15, 15, 8, 15, 8'h2F));
        run_to(151);
        chk_snap("dead", mk(15, 15, 8, 15, 8'hAF));
        run_to(152);
        cmd_byte = 8'h46;
        run_to(155);
        cmd_byte = 8'h00;
        run_to(161);
        chk_snap("dead_frozen", mk(15, 15, 8, 15, 8'hAF));
        run_to(162);
        cmd_byte = 8'h52;
        exp_q.push_back(mk(0, 0, 0, 0, 8'h00));
        run_to(163);
        cmd_byte = 8'h00;

        run_to(210);
        chk_snap("pre_sleep", mk(5, 5, 5, 5, 8'h05));
        cmd_byte = 8'h53;
        exp_q.push_back(mk(5, 5, 5, 5, 8'h75));
        run_to(211);
        cmd_byte = 8'h00;
        chk("asleep", int'(is_sleeping), 1);
        run_to(220);
        chk_snap("sleep_tick1", mk(6, 6, 6, 3, 8'h76));
        run_to(222);
        cmd_byte = 8'h46;
        run_to(224);
        cmd_byte = 8'h00;
        run_to(225);
        chk_snap("feed_ignored_asleep", mk(6, 6, 6, 3, 8'h76));
        run_to(230);
        chk_snap("sleep_tick2", mk(7, 7, 7, 1, 8'h77));
        run_to(240);
        chk_snap("sleep_tick3", mk(8, 8, 8, 0, 8'h78));
        chk("still_asleep", int'(is_sleeping), 1);
        run_to(241);
        chk("auto_wake", int'(is_sleeping), 0);
        chk("auto_wake_status", int'(status), 8'h38);

        run_to(312);
        chk_snap("dead_again", mk(15, 15, 15, 7, 8'hBF));
        cmd_byte = 8'h52;
        exp_q.push_back(mk(0, 0, 0, 0, 8'h00));
        run_to(313);
        cmd_byte = 8'h00;

        // Feed held for 50 cycles must be accepted exactly once.
        run_to(370);
        chk_snap("pre_feed", mk(6, 6, 6, 6, 8'h06));
        cmd_byte = 8'h46;
        exp_q.push_back(mk(2, 6, 7, 6, 8'h06));
        run_to(420);
        cmd_byte = 8'h00;
        chk_snap("feed_held", mk(7, 11, 12, 11, 8'h0B));

        run_to(425);
        cmd_byte = 8'h54;
`ifdef PET_STATS_CHEAT_EN
        exp_q.push_back(mk(8, 12, 13, 12, 8'h0C));
`endif
        run_to(426);
        cmd_byte = 8'h00;
        run_to(428);
`ifdef PET_STATS_CHEAT_EN
        chk_snap("cheat_tick", mk(8, 12, 13, 12, 8'h0C));
        chk("ack_count", acks, 6);
`else
        chk_snap("t_ignored", mk(7, 11, 12, 11, 8'h0B));
        chk("ack_count", acks, 5);
`endif
        run_to(432);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
